// File: rtl/his_readout_fsm.sv
// his_readout_fsm: drains a finished histogram RAM bank bin by bin onto a valid/ready stream.
// Optional feature macro READ_CLEAR_EN: zero each bin in RAM as it is handed downstream.
module his_readout_fsm #(
  parameter int BIN_NUM_PER_HIS   = 16,
  parameter int PIXEL_NUM_PER_RAM = 200,
  parameter int COUNT_W           = 16,
  parameter int ADDR_W            = 12
) (
  input  logic               clk_i,
  input  logic               res_i,
  input  logic               start_i,
  input  logic               bank_sel_i,
  output logic               ram_rd_en_o,
  output logic               ram_rd_bank_o,
  output logic [ADDR_W-1:0]  ram_rd_addr_o,
  input  logic [COUNT_W-1:0] ram_rd_data_i,
  output logic               ram_clr_en_o,
  output logic               bin_valid_o,
  input  logic               bin_ready_i,
  output logic [COUNT_W-1:0] bin_count_o,
  output logic [7:0]         bin_idx_o,
  output logic [7:0]         pixel_idx_o,
  output logic               bin_last_o,
  output logic               frame_last_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               overrun_o
);

  localparam logic [7:0]        BIN_LAST   = 8'(BIN_NUM_PER_HIS - 1);
  localparam logic [7:0]        PIX_LAST   = 8'(PIXEL_NUM_PER_RAM - 1);
  localparam logic [ADDR_W-1:0] BIN_STRIDE = ADDR_W'(BIN_NUM_PER_HIS);
  // Degenerate one-bin / one-pixel geometries make the very first bin already "last".
  localparam logic FIRST_BIN_LAST   = (BIN_NUM_PER_HIS == 1);
  localparam logic FIRST_FRAME_LAST = (BIN_NUM_PER_HIS == 1) && (PIXEL_NUM_PER_RAM == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WT,
    S_OUT,
    S_DONE
  } state_t;

  state_t             state_q;
  logic               rd_en_q;
  logic               bank_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [COUNT_W-1:0] count_q;
  logic               bin_valid_q;
  logic [7:0]         bin_q;
  logic [7:0]         pixel_q;
  logic               bin_last_q;
  logic               frame_last_q;
  logic               busy_q;
  logic               done_q;
  logic               overrun_q;

  logic               bin_wrap;
  logic [7:0]         bin_d;
  logic [7:0]         pixel_d;
  logic [ADDR_W-1:0]  addr_d;
  logic               bin_last_d;
  logic               frame_last_d;
  logic               handshake;

  assign handshake = bin_valid_q & bin_ready_i;

  // Position of the bin following the one currently offered downstream.
  always_comb begin
    bin_wrap     = (bin_q == BIN_LAST);
    bin_d        = bin_wrap ? 8'd0 : bin_q + 8'd1;
    pixel_d      = bin_wrap ? pixel_q + 8'd1 : pixel_q;
    addr_d       = ADDR_W'(pixel_d) * BIN_STRIDE + ADDR_W'(bin_d);
    bin_last_d   = (bin_d == BIN_LAST);
    frame_last_d = bin_last_d && (pixel_d == PIX_LAST);
  end

  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      state_q      <= S_IDLE;
      rd_en_q      <= 1'b0;
      bank_q       <= 1'b0;
      addr_q       <= '0;
      count_q      <= '0;
      bin_valid_q  <= 1'b0;
      bin_q        <= 8'd0;
      pixel_q      <= 8'd0;
      bin_last_q   <= 1'b0;
      frame_last_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rd_en_q   <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= start_i && (state_q != S_IDLE);
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            bank_q       <= bank_sel_i;
            bin_q        <= 8'd0;
            pixel_q      <= 8'd0;
            addr_q       <= '0;
            bin_last_q   <= FIRST_BIN_LAST;
            frame_last_q <= FIRST_FRAME_LAST;
            busy_q       <= 1'b1;
            rd_en_q      <= 1'b1;
            state_q      <= S_RD;
          end
        end
        S_RD: begin
          state_q <= S_WT;
        end
        S_WT: begin
          count_q     <= ram_rd_data_i;
          bin_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (handshake) begin
            bin_valid_q <= 1'b0;
            if (frame_last_q) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              bin_q        <= bin_d;
              pixel_q      <= pixel_d;
              addr_q       <= addr_d;
              bin_last_q   <= bin_last_d;
              frame_last_q <= frame_last_d;
              rd_en_q      <= 1'b1;
              state_q      <= S_RD;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef READ_CLEAR_EN
  // Clear lands on the handshake cycle itself, while the address still points at the bin.
  assign ram_clr_en_o = handshake;
`else
  assign ram_clr_en_o = 1'b0;
`endif

  assign ram_rd_en_o   = rd_en_q;
  assign ram_rd_bank_o = bank_q;
  assign ram_rd_addr_o = addr_q;
  assign bin_valid_o   = bin_valid_q;
  assign bin_count_o   = count_q;
  assign bin_idx_o     = bin_q;
  assign pixel_idx_o   = pixel_q;
  assign bin_last_o    = bin_last_q;
  assign frame_last_o  = frame_last_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_his_readout_fsm.sv
// Bench for his_readout_fsm with 2 pixels x 4 bins; RAM model preloaded with addr+1 in both banks.
module tb_his_readout_fsm;

  localparam int BIN = 4;
  localparam int PIX = 2;
  localparam int CW  = 16;
  localparam int AW  = 12;
`ifdef READ_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic          clk;
  logic          res;
  logic          start;
  logic          bank_sel;
  logic          ram_rd_en;
  logic          ram_rd_bank;
  logic [AW-1:0] ram_rd_addr;
  logic [CW-1:0] ram_rd_data;
  logic          ram_clr_en;
  logic          bin_valid;
  logic          bin_ready;
  logic [CW-1:0] bin_count;
  logic [7:0]    bin_idx;
  logic [7:0]    pixel_idx;
  logic          bin_last;
  logic          frame_last;
  logic          busy;
  logic          done;
  logic          overrun;

  his_readout_fsm #(
    .BIN_NUM_PER_HIS  (BIN),
    .PIXEL_NUM_PER_RAM(PIX),
    .COUNT_W          (CW),
    .ADDR_W           (AW)
  ) dut (
    .clk_i        (clk),
    .res_i        (res),
    .start_i      (start),
    .bank_sel_i   (bank_sel),
    .ram_rd_en_o  (ram_rd_en),
    .ram_rd_bank_o(ram_rd_bank),
    .ram_rd_addr_o(ram_rd_addr),
    .ram_rd_data_i(ram_rd_data),
    .ram_clr_en_o (ram_clr_en),
    .bin_valid_o  (bin_valid),
    .bin_ready_i  (bin_ready),
    .bin_count_o  (bin_count),
    .bin_idx_o    (bin_idx),
    .pixel_idx_o  (pixel_idx),
    .bin_last_o   (bin_last),
    .frame_last_o (frame_last),
    .busy_o       (busy),
    .done_o       (done),
    .overrun_o    (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: registered read, write-zero on clear, clear addresses logged.
  logic [CW-1:0] mem [0:1][0:15];
  logic [12:0]   clr_log [0:63];
  int            clr_n  = 0;
  bit            loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int bk = 0; bk < 2; bk++)
        for (int a = 0; a < 16; a++)
          mem[bk][a] <= 16'(a + 1);
      loaded <= 1'b1;
    end else begin
      if (ram_rd_en) ram_rd_data <= mem[ram_rd_bank][ram_rd_addr[3:0]];
      if (ram_clr_en) begin
        mem[ram_rd_bank][ram_rd_addr[3:0]] <= '0;
        if (clr_n < 64) clr_log[clr_n] <= {ram_rd_bank, ram_rd_addr};
        clr_n <= clr_n + 1;
      end
    end
  end

  typedef struct {
    logic [CW-1:0] cnt;
    logic [7:0]    bidx;
    logic [7:0]    pidx;
    logic          blast;
    logic          flast;
    logic [AW-1:0] addr;
  } vec_t;

  vec_t tbl [0:7];
  logic cleared [0:1][0:7];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({ram_rd_en, ram_rd_bank, ram_rd_addr, ram_clr_en, bin_valid, bin_count,
                bin_idx, pixel_idx, bin_last, frame_last, busy, done, overrun});
  endfunction

  // One scan: optional ready stall, overrun start, async reset, or start coinciding with done.
  task automatic scan(input bit bank, input int stall_bin, input int ovr_bin,
                      input int rst_bin, input bit start_at_done);
    int  b      = 0;
    int  stalls = 0;
    int  ending = 0;
    bit  ovr_pend = 1'b0;
    bit  ovr_done = 1'b0;
    logic [CW-1:0] exp_cnt;
    @(negedge clk);
    start = 1'b1; bank_sel = bank; bin_ready = 1'b1;
    for (int k = 1; k <= 300 && ending == 0; k++) begin
      @(negedge clk);
      start    = 1'b0;
      bank_sel = ~bank;
      chk("overrun", overrun, ovr_pend);
      ovr_pend = 1'b0;
      if (k == 1) chk("busy_after_start", busy, 1);
      if (ram_rd_en) begin
        if (b < 8) begin
          chk("rd_addr", ram_rd_addr, tbl[b].addr);
          chk("rd_bank", ram_rd_bank, bank);
        end else chk("rd_beyond_frame", b, 7);
      end
      if (done) begin
        chk("done_cycle", k, 25 + stalls);
        chk("bins_seen", b, 8);
        ending = 2;
        if (start_at_done) start = 1'b1;
      end else if (bin_valid) begin
        if (b < 8) begin
          exp_cnt = (CLR && cleared[bank][b]) ? '0 : tbl[b].cnt;
          chk("bin_count", bin_count, exp_cnt);
          chk("bin_idx", bin_idx, tbl[b].bidx);
          chk("pixel_idx", pixel_idx, tbl[b].pidx);
          chk("bin_last", bin_last, tbl[b].blast);
          chk("frame_last", frame_last, tbl[b].flast);
        end else chk("valid_beyond_frame", b, 7);
        if (b == ovr_bin && !ovr_done) begin
          start = 1'b1; ovr_pend = 1'b1; ovr_done = 1'b1;
        end
        if (b == rst_bin) begin
          #2 res = 1'b1;
          #1 chk("async_reset_outputs", all_outs(), 0);
          ending = 1;
        end else if (b == stall_bin && stalls < 5) begin
          if (stalls > 0) chk("stall_no_read", ram_rd_en, 0);
          bin_ready = 1'b0;
          stalls++;
        end else begin
          bin_ready = 1'b1;
          if (b < 8) cleared[bank][b] = CLR;
          b++;
        end
      end
    end
    if (ending == 0) chk("scan_timeout", 0, 1);
    if (ending == 2) begin
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_done", busy, 0);
      chk("overrun_at_done", overrun, start_at_done);
      chk("no_restart_after_done", ram_rd_en, 0);
      chk("done_one_cycle", done, 0);
    end
  endtask

  task automatic check_clears(input int base, input bit bank);
    int n;
    n = clr_n - base;
    chk("clear_count", n, CLR ? 8 : 0);
    for (int i = 0; i < n && i < 8 && base + i < 64; i++)
      chk("clear_addr", clr_log[base + i], {bank, 12'(i)});
  endtask

  int base;

  initial begin
    res = 1'b1; start = 1'b0; bank_sel = 1'b0; bin_ready = 1'b1;
    tbl[0] = '{16'd1, 8'd0, 8'd0, 1'b0, 1'b0, 12'd0};
    tbl[1] = '{16'd2, 8'd1, 8'd0, 1'b0, 1'b0, 12'd1};
    tbl[2] = '{16'd3, 8'd2, 8'd0, 1'b0, 1'b0, 12'd2};
    tbl[3] = '{16'd4, 8'd3, 8'd0, 1'b1, 1'b0, 12'd3};
    tbl[4] = '{16'd5, 8'd0, 8'd1, 1'b0, 1'b0, 12'd4};
    tbl[5] = '{16'd6, 8'd1, 8'd1, 1'b0, 1'b0, 12'd5};
    tbl[6] = '{16'd7, 8'd2, 8'd1, 1'b0, 1'b0, 12'd6};
    tbl[7] = '{16'd8, 8'd3, 8'd1, 1'b1, 1'b1, 12'd7};
    for (int bk = 0; bk < 2; bk++)
      for (int i = 0; i < 8; i++)
        cleared[bk][i] = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 0);
    res = 1'b0;

    base = clr_n;
    scan(1'b1, -1, -1, -1, 1'b0);
    @(negedge clk);
    check_clears(base, 1'b1);

    scan(1'b1, 2, 4, -1, 1'b1);

    scan(1'b0, -1, -1, 5, 1'b0);
    @(negedge clk);
    chk("held_in_reset", all_outs(), 0);
    res = 1'b0;

    base = clr_n;
    scan(1'b0, -1, -1, -1, 1'b0);
    @(negedge clk);
    check_clears(base, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
